// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : MEM-stage RV32I load/store unit with multi-cycle word RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALU_result_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        access_err_o
);

  localparam int         c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_LAST  = 4'(LATENCY - 1);

  logic [31:0]           r_mem [c_DEPTH];
  logic [3:0]            r_cnt;

  logic                  w_req;
  logic                  w_store;
  logic                  w_load;
  logic                  w_bad_code;
  logic                  w_misaligned;
  logic                  w_illegal;
  logic                  w_active;
  logic                  w_done;
  logic                  w_commit;
  logic [DEPTH_LOG2-1:0] w_index;
  logic [1:0]            w_lane;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_data;
  logic [31:0]           w_wdata;
  logic [3:0]            w_be;
  logic                  w_unused;

  // A simultaneous read+write request is handled purely as a store.
  assign w_req   = MemRead_i | MemWrite_i;
  assign w_store = MemWrite_i;
  assign w_load  = MemRead_i & ~MemWrite_i;
  assign w_index = ALU_result_i[DEPTH_LOG2+1:2];
  assign w_lane  = ALU_result_i[1:0];

  always_comb begin
    w_bad_code   = 1'b1;
    w_misaligned = 1'b0;
    case (funct3_i)
      3'b000: w_bad_code = 1'b0;
      3'b001: begin
        w_bad_code   = 1'b0;
        w_misaligned = w_lane[0];
      end
      3'b010: begin
        w_bad_code   = 1'b0;
        w_misaligned = |w_lane;
      end
      3'b100: w_bad_code = w_store;
      3'b101: begin
        w_bad_code   = w_store;
        w_misaligned = w_lane[0];
      end
      default: w_bad_code = 1'b1;
    endcase
  end

  assign w_illegal    = w_bad_code | w_misaligned;
  assign w_active     = ~rst_i & w_req & ~w_illegal;
  assign w_done       = (r_cnt == c_LAST);
  assign w_commit     = w_active & w_store & w_done;
  assign stall_o      = w_active & ~w_done;
  assign access_err_o = ~rst_i & w_req & w_illegal;

  // Counter falls back to 0 whenever the request completes, errors or drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (stall_o) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_word = r_mem[w_index];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load_data = '0;
    case (funct3_i)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = w_word;
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = '0;
    endcase
  end

  assign ReadData_o = (w_active & w_load & w_done) ? w_load_data : '0;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteData_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData_i[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_unused = ^ALU_result_i[31:DEPTH_LOG2+2];

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed bench with transaction-level memory model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  localparam logic [2:0] c_B  = 3'b000;
  localparam logic [2:0] c_H  = 3'b001;
  localparam logic [2:0] c_W  = 3'b010;
  localparam logic [2:0] c_BU = 3'b100;
  localparam logic [2:0] c_HU = 3'b101;

  logic        clk;
  logic        rst;
  logic        mr    [2];
  logic        mw    [2];
  logic [2:0]  f3r   [2];
  logic [31:0] ad    [2];
  logic [31:0] wdr   [2];
  logic [31:0] rdo   [2];
  logic        stall [2];
  logic        err   [2];

  logic        e_stall [2];
  logic        e_err   [2];
  logic [31:0] e_rd    [2];

  logic [7:0]  mm [2][1024];

  int          last_stalls [2];
  logic        last_err    [2];
  logic [31:0] last_rd     [2];

  int checks;
  int failures;

  mem_access_stage #(.DEPTH_LOG2(8), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr[0]), .MemWrite_i(mw[0]),
    .funct3_i(f3r[0]), .ALU_result_i(ad[0]), .WriteData_i(wdr[0]),
    .ReadData_o(rdo[0]), .stall_o(stall[0]), .access_err_o(err[0])
  );

  mem_access_stage #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr[1]), .MemWrite_i(mw[1]),
    .funct3_i(f3r[1]), .ALU_result_i(ad[1]), .WriteData_i(wdr[1]),
    .ReadData_o(rdo[1]), .stall_o(stall[1]), .access_err_o(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit code_ok;
    code_ok = st ? (f3 inside {3'b000, 3'b001, 3'b010})
                 : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    return code_ok && ((a % size_of(f3)) == 0);
  endfunction

  function automatic logic [31:0] model_load(input int i, input logic [2:0] f3, input logic [31:0] a);
    int          base;
    logic [31:0] w;
    logic [31:0] v;
    base = int'(a & 32'h3FC);
    w = {mm[i][base+3], mm[i][base+2], mm[i][base+1], mm[i][base]};
    v = w >> (8 * int'(a & 32'd3));
    if (size_of(f3) == 1) v = f3[2] ? (v & 32'hFF)   : 32'($signed(v[7:0]));
    if (size_of(f3) == 2) v = f3[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
    return v;
  endfunction

  task automatic model_store(input int i, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int b = 0; b < size_of(f3); b++) mm[i][int'(a & 32'h3FF) + b] = d[8*b +: 8];
  endtask

  task automatic idle(input int i);
    mr[i] = 1'b0; mw[i] = 1'b0; f3r[i] = 3'b000; ad[i] = '0; wdr[i] = '0;
    e_stall[i] = 1'b0; e_err[i] = 1'b0; e_rd[i] = '0;
  endtask

  // One request: held for the full access time if legal, one cycle if not.
  task automatic txn(input int i, input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    bit ok;
    int n;
    ok = legal(wr, f3, a);
    n  = ok ? lat(i) : 1;
    mr[i] = rd; mw[i] = wr; f3r[i] = f3; ad[i] = a; wdr[i] = wd;
    last_stalls[i] = 0; last_err[i] = 1'b0; last_rd[i] = '0;
    for (int k = 0; k < n; k++) begin
      e_err[i]   = !ok;
      e_stall[i] = ok && (k < n - 1);
      e_rd[i]    = (ok && rd && !wr && k == n - 1) ? model_load(i, f3, a) : 32'd0;
      @(negedge clk);
      last_stalls[i] += int'(stall[i]);
      last_err[i] |= err[i];
      if (k == n - 1) last_rd[i] = rdo[i];
      @(posedge clk);
      #1;
    end
    if (ok && wr) model_store(i, f3, a, wd);
    idle(i);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cyc_stall%0d", i), 32'(stall[i]), 32'(e_stall[i]));
      chk($sformatf("cyc_err%0d", i),   32'(err[i]),   32'(e_err[i]));
      chk($sformatf("cyc_rdata%0d", i), rdo[i],        e_rd[i]);
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle(0);
    idle(1);
    @(negedge clk);
    chk("reset_stall", 32'(stall[0]), 32'd0);
    chk("reset_rdata", rdo[0], 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic word store / load
    txn(0, 0, 1, c_W, 32'h10, 32'hDEADBEEF);
    chk("sw_stalls", 32'(last_stalls[0]), 32'd2);
    txn(0, 1, 0, c_W, 32'h10, 32'h0);
    chk("lw_stalls", 32'(last_stalls[0]), 32'd2);
    chk("lw_data", last_rd[0], 32'hDEADBEEF);

    // Byte and half lanes
    txn(0, 0, 1, c_W, 32'h20, 32'h8001F07F);
    txn(0, 0, 1, c_B, 32'h21, 32'h000000AA);
    txn(0, 1, 0, c_W,  32'h20, 32'h0); chk("lw_merge", last_rd[0], 32'h8001AA7F);
    txn(0, 1, 0, c_B,  32'h21, 32'h0); chk("lb",  last_rd[0], 32'hFFFFFFAA);
    txn(0, 1, 0, c_BU, 32'h21, 32'h0); chk("lbu", last_rd[0], 32'h000000AA);
    txn(0, 1, 0, c_H,  32'h22, 32'h0); chk("lh",  last_rd[0], 32'hFFFF8001);
    txn(0, 1, 0, c_HU, 32'h22, 32'h0); chk("lhu", last_rd[0], 32'h00008001);

    // Errors
    txn(0, 0, 1, c_W, 32'h30, 32'h11223344);
    txn(0, 1, 0, c_W, 32'h13, 32'h0);
    chk("lw_mis_err", 32'(last_err[0]), 32'd1);
    chk("lw_mis_stall", 32'(last_stalls[0]), 32'd0);
    chk("lw_mis_rd", last_rd[0], 32'd0);
    txn(0, 0, 1, c_H, 32'h31, 32'h0000BEEF);
    chk("sh_mis_err", 32'(last_err[0]), 32'd1);
    txn(0, 1, 0, c_W, 32'h30, 32'h0); chk("sh_mis_nowrite", last_rd[0], 32'h11223344);
    txn(0, 1, 0, 3'b011, 32'h30, 32'h0);
    chk("bad_f3_err", 32'(last_err[0]), 32'd1);

    // Reset in the middle of a store
    txn(0, 0, 1, c_W, 32'h40, 32'h0BADF00D);
    mr[0] = 1'b0; mw[0] = 1'b1; f3r[0] = c_W; ad[0] = 32'h40; wdr[0] = 32'h12345678;
    e_stall[0] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    e_stall[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", 32'(stall[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(0);
    txn(0, 1, 0, c_W, 32'h40, 32'h0);
    chk("rst_drop_data", last_rd[0], 32'h0BADF00D);
    chk("rst_restart_stalls", 32'(last_stalls[0]), 32'd2);

    // Request withdrawn mid-access commits nothing
    mw[0] = 1'b1; f3r[0] = c_W; ad[0] = 32'h40; wdr[0] = 32'h99999999;
    e_stall[0] = 1'b1;
    @(posedge clk);
    #1 idle(0);
    @(posedge clk);
    #1;
    txn(0, 1, 0, c_W, 32'h40, 32'h0);
    chk("flush_data", last_rd[0], 32'h0BADF00D);
    chk("flush_stalls", 32'(last_stalls[0]), 32'd2);

    // Address wrap and read/write collision
    txn(0, 0, 1, c_W, 32'h400, 32'hCAFEF00D);
    txn(0, 1, 0, c_W, 32'h0, 32'h0); chk("wrap", last_rd[0], 32'hCAFEF00D);
    txn(0, 1, 1, c_W, 32'h50, 32'h00000055);
    chk("both_rd", last_rd[0], 32'd0);
    chk("both_stalls", 32'(last_stalls[0]), 32'd2);
    txn(0, 1, 0, c_W, 32'h50, 32'h0); chk("both_stored", last_rd[0], 32'h00000055);

    // Single-cycle build: alternating store/load each cycle
    for (int k = 0; k < 4; k++) begin
      txn(1, 0, 1, c_W, 32'(8 * k), 32'hA5000000 + 32'(k * 17));
      chk("l1_sw_stalls", 32'(last_stalls[1]), 32'd0);
      txn(1, 1, 0, c_W, 32'(8 * k), 32'h0);
      chk("l1_lw_stalls", 32'(last_stalls[1]), 32'd0);
      chk("l1_lw_data", last_rd[1], 32'hA5000000 + 32'(k * 17));
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
